// File: rtl/pipeio_pkg.sv
// Shared definitions for the memory-mapped I/O responder: register offsets,
// handshake state encoding and STATUS bit positions.
package pipeio_pkg;

  localparam int unsigned PORT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] OFF_OUT0   = 8'h00;
  localparam logic [7:0] OFF_OUT1   = 8'h04;
  localparam logic [7:0] OFF_OUT2   = 8'h08;
  localparam logic [7:0] OFF_IN0    = 8'h10;
  localparam logic [7:0] OFF_IN1    = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;
  localparam logic [7:0] OFF_CYCLE  = 8'h1C;

  localparam int STAT_IN0 = 0;
  localparam int STAT_IN1 = 1;

endpackage

// File: rtl/pipeio_sync2.sv
// Two-flop synchroniser for an asynchronous input word, with a one-cycle
// pulse whenever the synchronised value differs from the previous cycle.
module pipeio_sync2
  import pipeio_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [PORT_W-1:0] async_i,
  output logic [PORT_W-1:0] sync_o,
  output logic              change_o
);

  logic [PORT_W-1:0] meta_q;
  logic [PORT_W-1:0] sync_q;
  logic [PORT_W-1:0] prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign change_o = |(sync_q ^ prev_q);

endmodule

// File: rtl/pipeio_responder.sv
// I/O window responder for the MEM stage: output port registers, synchronised
// input ports with change flags, a free-running cycle counter, and a
// valid/ready request channel answered by a one-cycle response pulse.
module pipeio_responder
  import pipeio_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = 32'h0000_FF00,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_out,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;

  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic [31:0] out2_q, out2_d;
  logic [31:0] cycle_q, cycle_d;
  logic [1:0]  flag_q, flag_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        hit_q, hit_d;

  logic [31:0] in0_sync, in1_sync;
  logic        in0_chg, in1_chg;

  logic        accept;
  logic        win_hit;
  logic        map_hit;
  logic        wr_en;
  logic [7:0]  off;
  logic [31:0] rd_val;
  logic [1:0]  chg_vec;
  logic [1:0]  w1c_vec;
  logic        unused_addr_bits;

  pipeio_sync2 u_sync_in0 (
    .clock    (clock),
    .reset    (reset),
    .async_i  (in_port0),
    .sync_o   (in0_sync),
    .change_o (in0_chg)
  );

  pipeio_sync2 u_sync_in1 (
    .clock    (clock),
    .reset    (reset),
    .async_i  (in_port1),
    .sync_o   (in1_sync),
    .change_o (in1_chg)
  );

  assign unused_addr_bits = ^req_addr[1:0];

  assign accept  = req_valid && req_ready;
  assign win_hit = (req_addr[31:8] == IO_BASE[31:8]);
  assign off     = {req_addr[7:2], 2'b00};
  assign wr_en   = accept && req_write && map_hit;

  always_comb begin
    map_hit = win_hit;
    rd_val  = '0;
    case (off)
      OFF_OUT0:   rd_val = out0_q;
      OFF_OUT1:   rd_val = out1_q;
      OFF_OUT2:   rd_val = out2_q;
      OFF_IN0:    rd_val = in0_sync;
      OFF_IN1:    rd_val = in1_sync;
      OFF_STATUS: rd_val = {30'd0, flag_q};
      OFF_CYCLE:  rd_val = cycle_q;
      default:    map_hit = 1'b0;
    endcase
  end

  // Side effects and the response payload are all captured at the accept edge.
  always_comb begin
    chg_vec           = '0;
    chg_vec[STAT_IN0] = in0_chg;
    chg_vec[STAT_IN1] = in1_chg;
    w1c_vec           = (wr_en && off == OFF_STATUS) ? req_wdata[1:0] : 2'b00;

    out0_d  = (wr_en && off == OFF_OUT0) ? req_wdata : out0_q;
    out1_d  = (wr_en && off == OFF_OUT1) ? req_wdata : out1_q;
    out2_d  = (wr_en && off == OFF_OUT2) ? req_wdata : out2_q;
    cycle_d = (wr_en && off == OFF_CYCLE) ? 32'd0 : cycle_q + 32'd1;
    flag_d  = (flag_q & ~w1c_vec) | chg_vec;

    rdata_d = rdata_q;
    err_d   = err_q;
    hit_d   = hit_q;
    if (accept) begin
      rdata_d = (req_write || !map_hit) ? 32'd0 : rd_val;
      err_d   = !map_hit;
      hit_d   = map_hit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      cycle_q <= '0;
      flag_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      cycle_q <= cycle_d;
      flag_q  <= flag_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) state_d = RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields are forced to zero outside the response pulse.
  always_comb begin
    req_ready = (state_q == IDLE) && !reset;
    rsp_valid = (state_q == RESP);
    rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    rsp_err   = rsp_valid && err_q;
    io_out    = rsp_valid && hit_q;
  end

  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign out_port2 = out2_q;

endmodule

// File: tb/tb_pipeio_responder.sv
// Bench for pipeio_responder: table of load/store vectors with a response
// scoreboard, plus hand sequences for timing, flags, counter and reset.
module tb_pipeio_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_write;
  logic [31:0] req_addr, req_wdata, in_port0, in_port1;
  logic        req_ready, rsp_valid, rsp_err, io_out;
  logic [31:0] rsp_rdata, out_port0, out_port1, out_port2;

  logic        reset3, req_valid3;
  logic        req_ready3, rsp_valid3, rsp_err3, io_out3;
  logic [31:0] rsp_rdata3, out3_0, out3_1, out3_2;

  pipeio_responder #(.IO_BASE(32'h0000_FF00), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .io_out(io_out),
    .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2)
  );

  pipeio_responder #(.IO_BASE(32'h0000_FF00), .WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset3), .req_valid(req_valid3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .io_out(io_out3),
    .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out3_0), .out_port1(out3_1), .out_port2(out3_2)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        io;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        io;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   edge_no = 0;
  int   last_acc = 0;
  int   rsp3_cnt = 0;
  bit   started = 1'b0;

  always @(posedge clock) edge_no <= edge_no + 1;
  always @(negedge clock) if (rsp_valid3 === 1'b1) rsp3_cnt <= rsp3_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("io_out", {31'd0, io_out}, {31'd0, e.io});
      end
    end else if (started && (rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || io_out !== 1'b0)) begin
      n_vec++;
      n_miss++;
      $display("FAIL idle_rsp_fields: got rdata=%h err=%b io=%b, expected all 0", rsp_rdata, rsp_err, io_out);
    end
  end

  // cyc_from >= 0: expected read data is the CYCLE value at the accept edge,
  // counted from a counter that was zeroed at edge cyc_from.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_io,
                       input int cyc_from);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (req_ready !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL ready_timeout: got req_ready=%b, expected 1 within 50 cycles", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    last_acc  = edge_no + 1;
    e.rdata   = (cyc_from >= 0) ? 32'(last_acc - cyc_from - 1) : exp_rd;
    e.err     = exp_err;
    e.io      = exp_io;
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL rsp_timeout: got no response for addr %h, expected one", addr);
      sb.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   ts;
    int   k;

    reset = 1'b1; reset3 = 1'b1;
    req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; in_port0 = '0; in_port1 = '0;

    vecs[0]  = '{1'b1, 32'h0000_FF00, 32'h1111_2222, 32'h0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h0000_FF08, 32'h3333_4444, 32'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0000_FF00, 32'h0, 32'h1111_2222, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_FF05, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_FF08, 32'h0, 32'h3333_4444, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_FF14, 32'hAAAA_5555, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_FF14, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_FF20, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_FE00, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_FF24, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_FF00, 32'h0, 32'h1111_2222, 1'b0, 1'b1};

    // Reset for two cycles, then check the reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", {31'd0, req_ready}, 32'd0);
    check("rsp_valid_reset", {31'd0, rsp_valid}, 32'd0);
    check("out_port0_reset", out_port0, 32'd0);
    check("out_port1_reset", out_port1, 32'd0);
    check("out_port2_reset", out_port2, 32'd0);
    reset = 1'b0; reset3 = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    started = 1'b1;

    // Store timing with one wait state.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_FF04; req_wdata = 32'hDEAD_BEEF;
    sb.push_back('{32'h0, 1'b0, 1'b1});
    @(negedge clock);
    req_valid = 1'b0;
    check("out_port1_T+1", out_port1, 32'hDEAD_BEEF);
    check("ready_T+1", {31'd0, req_ready}, 32'd0);
    check("rsp_valid_T+1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    check("rsp_valid_T+2", {31'd0, rsp_valid}, 32'd1);
    check("ready_T+2", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    check("ready_T+3", {31'd0, req_ready}, 32'd1);
    check("rsp_valid_T+3", {31'd0, rsp_valid}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    for (int i = 0; i < 12; i++)
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].io, -1);
    check("out_port0_kept", out_port0, 32'h1111_2222);
    check("out_port1_kept", out_port1, 32'hDEAD_BEEF);
    check("out_port2_kept", out_port2, 32'h3333_4444);

    // Input change, status read and W1C.
    @(negedge clock);
    in_port0 = 32'h0000_005A;
    repeat (4) @(posedge clock);
    issue(1'b0, 32'h0000_FF10, 32'h0, 32'h0000_005A, 1'b0, 1'b1, -1);
    issue(1'b0, 32'h0000_FF18, 32'h0, 32'h0000_0001, 1'b0, 1'b1, -1);
    issue(1'b1, 32'h0000_FF18, 32'h1, 32'h0, 1'b0, 1'b1, -1);
    issue(1'b0, 32'h0000_FF18, 32'h0, 32'h0, 1'b0, 1'b1, -1);

    // in_port1 changes so its flag sets on the very edge that accepts a W1C of bit1.
    @(negedge clock);
    in_port1 = 32'h0000_0003;
    @(posedge clock);
    @(posedge clock);
    issue(1'b1, 32'h0000_FF18, 32'h2, 32'h0, 1'b0, 1'b1, -1);
    issue(1'b0, 32'h0000_FF18, 32'h0, 32'h0000_0002, 1'b0, 1'b1, -1);
    issue(1'b0, 32'h0000_FF14, 32'h0, 32'h0000_0003, 1'b0, 1'b1, -1);
    issue(1'b1, 32'h0000_FF18, 32'h2, 32'h0, 1'b0, 1'b1, -1);
    issue(1'b0, 32'h0000_FF18, 32'h0, 32'h0, 1'b0, 1'b1, -1);

    // Cycle counter: zero it, wait, read back the distance.
    issue(1'b1, 32'h0000_FF1C, 32'h0, 32'h0, 1'b0, 1'b1, -1);
    ts = last_acc;
    repeat (10) @(posedge clock);
    issue(1'b0, 32'h0000_FF1C, 32'h0, 32'h0, 1'b0, 1'b1, ts);

    // Counter wrap from all-ones.
    @(negedge clock);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    @(posedge clock);
    #1;
    check("cycle_wrap", dut.cycle_q, 32'd0);
    issue(1'b0, 32'h0000_FF1C, 32'h0, 32'h0, 1'b0, 1'b1, -1);

    // Three wait states: reset during WAIT discards the response.
    @(negedge clock);
    check("ready3_idle", {31'd0, req_ready3}, 32'd1);
    req_write = 1'b1; req_addr = 32'h0000_FF08; req_wdata = 32'h1234_5678; req_valid3 = 1'b1;
    @(negedge clock);
    req_valid3 = 1'b0;
    check("out3_2_T+1", out3_2, 32'h1234_5678);
    check("ready3_busy", {31'd0, req_ready3}, 32'd0);
    @(negedge clock);
    reset3 = 1'b1;
    #1;
    check("ready3_in_reset", {31'd0, req_ready3}, 32'd0);
    @(negedge clock);
    check("out3_2_reset", out3_2, 32'd0);
    check("rsp_valid3_reset", {31'd0, rsp_valid3}, 32'd0);
    check("rsp3_fields_reset", {rsp_rdata3[29:0], rsp_err3, io_out3}, 32'd0);
    reset3 = 1'b0;
    #1;
    check("ready3_after_reset", {31'd0, req_ready3}, 32'd1);
    repeat (8) @(negedge clock);
    check("rsp3_discarded", rsp3_cnt, 32'd0);

    // Normal load on the three-wait-state instance: response four cycles after accept.
    req_write = 1'b0; req_addr = 32'h0000_FF08; req_valid3 = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      req_valid3 = 1'b0;
      k++;
    end while (rsp_valid3 !== 1'b1 && k < 20);
    check("w3_latency", k, 32'd4);
    check("w3_rdata", rsp_rdata3, 32'd0);
    check("w3_io", {31'd0, io_out3}, 32'd1);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
